booth_mul_dp: RTL and testbench



---
 rtl/booth_mul_dp_pkg.sv | 23 ++
 rtl/booth_mul_dp_if.sv | 31 +++
 rtl/booth_mul_dp_add_sub33.sv | 76 +++++++
 rtl/booth_mul_dp.sv | 77 +++++++
 tb/tb_booth_mul_dp.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/booth_mul_dp_pkg.sv
// Shared multiplier package: controller state encodings and sizes.
// Imported by the Booth datapath and the multiplier controller.
package mul_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int AW    = WIDTH + 1;

  typedef enum logic [1:0] {
    START_STATE = 2'b00,
    MULT_STATE  = 2'b01,
    DONE_STATE  = 2'b10,
    ILL_STATE   = 2'b11
  } state_t;

  // Sign-extend an operand to accumulator width.
  function automatic logic [AW-1:0] sext(
    input logic [WIDTH-1:0] v
  );
    return {v[WIDTH-1], v};
  endfunction

endpackage

// File: rtl/booth_mul_dp_if.sv
// Controller-to-datapath bus for the Booth multiplier.
// master: controller side, slave: datapath side.
interface booth_mul_dp_if;
  import mul_pkg::*;

  logic [1:0]       state;
  logic [5:0]       counter;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [2*WIDTH-1:0] result;
  logic             op_done;

  modport master (
    output state,
    output counter,
    output multiplicand,
    output multiplier,
    input  result,
    input  op_done
  );

  modport slave (
    input  state,
    input  counter,
    input  multiplicand,
    input  multiplier,
    output result,
    output op_done
  );

endinterface

// File: rtl/booth_mul_dp_add_sub33.sv
// 33-bit adder/subtractor from five chained 8-bit CLA slices.
// Subtraction is operand inversion plus carry-in of one.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Every carry is expanded from g/p/cin only, no ripple.
  function automatic logic [8:0] carries(
    input logic [7:0] gi,
    input logic [7:0] pi,
    input logic       ci
  );
    logic [8:0] r;
    r = '0;
    r[0] = ci;
    for (int i = 0; i < 8; i++) begin
      logic t;
      logic pp;
      t  = gi[i];
      pp = pi[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & gi[j]);
        pp = pp & pi[j];
      end
      r[i+1] = t | (pp & ci);
    end
    return r;
  endfunction

  assign g    = a & b;
  assign p    = a ^ b;
  assign c    = carries(g, p, cin);
  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

module add_sub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] y
);

  logic [39:0] ax;
  logic [39:0] bx;
  logic [39:0] s;
  logic [5:0]  c;
  logic        unused_hi;

  assign ax   = {{7{a[32]}}, a};
  assign bx   = {{7{b[32]}}, b} ^ {40{sub}};
  assign c[0] = sub;

  for (genvar k = 0; k < 5; k++) begin : g_cla
    cla8 u_cla (
      .a    (ax[8*k +: 8]),
      .b    (bx[8*k +: 8]),
      .cin  (c[k]),
      .sum  (s[8*k +: 8]),
      .cout (c[k+1])
    );
  end

  assign y         = s[32:0];
  assign unused_hi = ^{s[39:33], c[5]};

endmodule

// File: rtl/booth_mul_dp.sv
// Radix-2 Booth datapath for the signed multiplier.
// Steps one add/sub-and-shift per multiply cycle under controller state.
import mul_pkg::*;

module booth_mul_dp #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  booth_mul_dp_if.slave bus
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   nxt;
  logic             sub;

  // 10 subtracts the multiplicand, 01 adds it.
  assign sub = q[0] & ~q_m1;

  add_sub33 u_addsub (
    .a   (acc),
    .b   (sext(mcand)),
    .sub (sub),
    .y   (sum)
  );

  // Booth recode selects the updated accumulator.
  always_comb begin
    nxt = acc;
    unique case (1'b1)
      (q[0] ^ q_m1): nxt = sum;
      default:       nxt = acc;
    endcase
  end

  // Load, iterate/shift, capture product; done and illegal hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand       <= '0;
      acc         <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      bus.result  <= '0;
      bus.op_done <= 1'b0;
    end else begin
      unique case (bus.state)
        START_STATE: begin
          mcand       <= bus.multiplicand;
          q           <= bus.multiplier;
          acc         <= '0;
          q_m1        <= 1'b0;
          bus.result  <= '0;
          bus.op_done <= 1'b0;
        end
        MULT_STATE: begin
          if (bus.counter < 6'(ITER)) begin
            acc  <= {nxt[WIDTH], nxt[WIDTH:1]};
            q    <= {nxt[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
          end else if (bus.counter == 6'(ITER)) begin
            bus.result  <= {acc[WIDTH-1:0], q};
            bus.op_done <= 1'b1;
          end
        end
        DONE_STATE, ILL_STATE: begin
          bus.op_done <= bus.op_done;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_dp.sv
// Self-checking bench for booth_mul_dp.
// Plays the controller; compares against plain signed multiplication.
module tb_booth_mul_dp;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  booth_mul_dp_if bus();

  booth_mul_dp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.state        = START_STATE;
    bus.counter      = 6'd0;
    bus.multiplicand = a;
    bus.multiplier   = b;
  endtask

  task automatic do_mult(input int k);
    @(negedge clk);
    bus.state   = MULT_STATE;
    bus.counter = 6'(k);
  endtask

  // Counter 0..32, then sample and move to done.
  task automatic finish_mult(output logic [63:0] r,
                             output logic d,
                             output logic pre);
    for (int k = 0; k <= 32; k++) begin
      do_mult(k);
      if (k == 32) pre = bus.op_done;
    end
    @(negedge clk);
    r = bus.result;
    d = bus.op_done;
    bus.state   = DONE_STATE;
    bus.counter = 6'd0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output logic [63:0] r, output logic d,
                     output logic pre);
    do_start(a, b);
    finish_mult(r, d, pre);
  endtask

  logic [63:0] r;
  logic [63:0] hold_r;
  logic        d;
  logic        pre;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    bus.state        = START_STATE;
    bus.counter      = 6'd0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    tbl[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{32'h0000_0000, 32'h1234_5678, 64'h0};
    tbl[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    tbl[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

    #1;
    check("reset_result", bus.result, 64'h0);
    check("reset_done", 64'(bus.op_done), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].a, tbl[i].b, r, d, pre);
      check($sformatf("tbl%0d_result", i), r, tbl[i].exp);
      check($sformatf("tbl%0d_done", i), 64'(d), 64'h1);
      check($sformatf("tbl%0d_early", i), 64'(pre), 64'h0);
    end

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 6 == 1) rb = 32'hFFFF_FFFF;
      run(ra, rb, r, d, pre);
      check($sformatf("rand%0d_result", i), r, ref_mul(ra, rb));
      check($sformatf("rand%0d_done", i), 64'(d), 64'h1);
    end

    // Done state holds while operands wander.
    run(32'd123, 32'hFFFF_FF00, r, d, pre);
    bus.multiplicand = 32'hDEAD_BEEF;
    bus.multiplier   = 32'h1111_1111;
    repeat (3) @(negedge clk);
    check("done_hold_result", bus.result, ref_mul(32'd123, 32'hFFFF_FF00));
    check("done_hold_flag", 64'(bus.op_done), 64'h1);

    // Leaving done: first start edge clears outputs.
    do_start(32'd1, 32'd1);
    @(negedge clk);
    check("restart_clear_result", bus.result, 64'h0);
    check("restart_clear_done", 64'(bus.op_done), 64'h0);

    // Illegal state never asserts op_done.
    bus.state = ILL_STATE;
    repeat (3) @(negedge clk);
    check("illegal_done", 64'(bus.op_done), 64'h0);

    // Operands changed mid-multiply are ignored.
    do_start(32'd3, 32'd4);
    for (int k = 0; k <= 32; k++) begin
      do_mult(k);
      if (k == 5) begin
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'd5;
      end
    end
    @(negedge clk);
    check("midchange_result", bus.result, 64'd12);
    bus.state = DONE_STATE;

    // Abort at counter 10, then restart with 6 x 7.
    do_start(32'd3, 32'd9);
    for (int k = 0; k < 10; k++) do_mult(k);
    do_start(32'd6, 32'd7);
    @(negedge clk);
    check("clear_result", bus.result, 64'h0);
    check("clear_done", 64'(bus.op_done), 64'h0);
    finish_mult(r, d, pre);
    check("after_clear_result", r, 64'd42);
    check("after_clear_done", 64'(d), 64'h1);

    // Async reset while a product is showing.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_done_result", bus.result, 64'h0);
    check("async_rst_done_flag", 64'(bus.op_done), 64'h0);
    #1 reset_n = 1'b1;

    // Reset pulse at counter 20, then 9 x -9.
    do_start(32'd11, 32'd13);
    for (int k = 0; k <= 20; k++) do_mult(k);
    #2 reset_n = 1'b0;
    #1;
    check("rst20_result", bus.result, 64'h0);
    check("rst20_done", 64'(bus.op_done), 64'h0);
    #1 reset_n = 1'b1;
    run(32'd9, 32'hFFFF_FFF7, r, d, pre);
    check("post_rst_result", r, 64'hFFFF_FFFF_FFFF_FFAF);
    check("post_rst_done", 64'(d), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
